// File: rtl/cic_decimator.sv
// cic_decimator: STAGES-order CIC decimator with run-time ratio R = 2^dec_sel.
// Integrators run at the input rate and combs at the output rate. The output
// is scaled by R^STAGES so that the DC gain is exactly 1.
// Optional macro CIC_ROUND_EN enables round-half-up before the output shift.
// If it is undefined, the shift truncates toward minus infinity.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   din         signed input sample (DATA_W)
//   din_valid   input qualifier, always accepted
//   dec_sel     ratio select; values above MAX_SEL are clamped
//   dout        signed decimated sample, held between strobes
//   dout_valid  one-cycle strobe for a new dout
module cic_decimator #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned MAX_SEL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_valid,
  input  logic        [2:0]        dec_sel,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid
);

  localparam int unsigned ACC_W = DATA_W + STAGES * MAX_SEL;
  localparam int unsigned CNT_W = (MAX_SEL > 0) ? MAX_SEL : 1;
  localparam int unsigned SH_W  = ($clog2(STAGES * MAX_SEL + 1) > 0) ?
                                  $clog2(STAGES * MAX_SEL + 1) : 1;

  logic signed [ACC_W-1:0]  integ_q    [STAGES];
  logic signed [ACC_W-1:0]  integ_d    [STAGES];
  logic signed [ACC_W-1:0]  comb_dly_q [STAGES];
  logic signed [ACC_W-1:0]  comb_dly_d [STAGES];
  logic signed [ACC_W-1:0]  comb_c     [STAGES+1];
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [2:0]        sel_q, sel_d, sel_c;
  logic                     chg_q, chg_d;
  logic                     pend_q, pend_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic                     dout_valid_q, dout_valid_d;
  logic        [CNT_W:0]    r_c;
  logic        [CNT_W-1:0]  last_c;
  logic        [SH_W-1:0]   sh_c;
  logic signed [ACC_W-1:0]  pre_c, scaled_c;

  // Clamp the requested ratio to the supported range.
  assign sel_c = (dec_sel > 3'(MAX_SEL)) ? 3'(MAX_SEL) : dec_sel;

  // Comb chain, sample counter terminal value and output scaling.
  always_comb begin
    comb_c[0] = integ_q[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      comb_c[k+1] = comb_c[k] - comb_dly_q[k];
    end
    r_c    = (CNT_W+1)'(1) << sel_q;
    last_c = CNT_W'(r_c - (CNT_W+1)'(1));
    sh_c   = SH_W'(STAGES * int'(sel_q));
    pre_c  = comb_c[STAGES];
`ifdef CIC_ROUND_EN
    if (sh_c != '0) begin
      pre_c = comb_c[STAGES] + $signed(ACC_W'(1) << (sh_c - SH_W'(1)));
    end
`endif
    scaled_c = pre_c >>> sh_c;
  end

  // Next-state logic. A ratio change flushes all state, and the flush
  // takes priority over any pending output or accepted sample.
  always_comb begin
    integ_d      = integ_q;
    comb_dly_d   = comb_dly_q;
    cnt_d        = cnt_q;
    pend_d       = 1'b0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sel_d        = sel_c;
    chg_d        = (sel_c != sel_q);
    if (chg_q) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_d[k]    = '0;
        comb_dly_d[k] = '0;
      end
      cnt_d = '0;
    end else begin
      if (pend_q) begin
        for (int k = 0; k < STAGES; k++) begin
          comb_dly_d[k] = comb_c[k];
        end
        dout_d       = DATA_W'(scaled_c);
        dout_valid_d = 1'b1;
      end
      if (din_valid) begin
        integ_d[0] = integ_q[0] + ACC_W'(din);
        for (int k = 1; k < STAGES; k++) begin
          integ_d[k] = integ_q[k] + integ_q[k-1];
        end
        if (cnt_q == last_c) begin
          cnt_d  = '0;
          pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k]    <= '0;
        comb_dly_q[k] <= '0;
      end
      cnt_q        <= '0;
      sel_q        <= '0;
      chg_q        <= 1'b0;
      pend_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      integ_q      <= integ_d;
      comb_dly_q   <= comb_dly_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      chg_q        <= chg_d;
      pend_q       <= pend_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: randomized and directed bench for cic_decimator.
// The reference model computes each output from the closed-form CIC
// response. The integrator cascade is a binomial-weighted sum of the
// samples, and the comb cascade is a binomial difference at the output rate.
module tb_cic_decimator;

  localparam int DATA_W  = 16;
  localparam int STAGES  = 3;
  localparam int MAX_SEL = 4;
  localparam int ACC_W   = DATA_W + STAGES * MAX_SEL;

  logic                     clk;
  logic                     rst_n;
  logic signed [DATA_W-1:0] din;
  logic                     din_valid;
  logic        [2:0]        dec_sel;
  logic signed [DATA_W-1:0] dout;
  logic                     dout_valid;

  cic_decimator #(.DATA_W(DATA_W), .STAGES(STAGES), .MAX_SEL(MAX_SEL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .dec_sel    (dec_sel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int val; } exp_t;
  exp_t expq[$];
  int   obs[$];
  int   xs[$];
  int   exp_dout = 0;
  int   cur_sel  = 0;
  int   skip     = 0;
  int   n_vec    = 0;
  int   n_bad    = 0;

  task automatic check(input string tag, input longint got, input longint expv);
    n_vec++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    if (n < k || n < 0) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic longint wrap_acc(input longint v);
    longint m = v & ((longint'(1) << ACC_W) - 1);
    if (m[ACC_W-1]) m = m - (longint'(1) << ACC_W);
    return m;
  endfunction

  // Value of the last integrator after the m-th sample since the last clear.
  function automatic longint integ_at(input int m);
    longint s = 0;
    if (m < 0) return 0;
    for (int j = 0; j <= m; j++) s += longint'(xs[j]) * binom(m - j, STAGES - 1);
    return s;
  endfunction

  function automatic int model_out();
    int     n = xs.size() - 1;
    int     r = 1 << cur_sel;
    int     sh = STAGES * cur_sel;
    longint y = 0;
    longint v;
    logic signed [DATA_W-1:0] t;
    for (int k = 0; k <= STAGES; k++) begin
      if (k % 2 == 1) y -= binom(STAGES, k) * integ_at(n - k * r);
      else            y += binom(STAGES, k) * integ_at(n - k * r);
    end
    v = wrap_acc(y);
`ifdef CIC_ROUND_EN
    if (sh > 0) v = wrap_acc(v + (longint'(1) << (sh - 1)));
`endif
    v = v >>> sh;
    t = DATA_W'(v);
    return int'(t);
  endfunction

  function automatic int clampsel(input int s);
    return (s > MAX_SEL) ? MAX_SEL : s;
  endfunction

  // Apply one cycle of input and advance the model.
  task automatic drive(input bit v, input int d);
    din_valid = v;
    din       = DATA_W'(d);
    if (skip > 0) begin
      skip--;
      if (skip == 0) xs.delete();
    end else if (v) begin
      xs.push_back(d);
      if (xs.size() % (1 << cur_sel) == 0) expq.push_back('{cyc + 2, model_out()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0);
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic set_sel(input int s);
    dec_sel = 3'(s);
    if (clampsel(s) != cur_sel) begin
      cur_sel = clampsel(s);
      skip    = 2;
    end
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expq.delete();
    xs.delete();
    skip     = 0;
    exp_dout = 0;
    check("rst_dout", longint'(dout), 0);
    check("rst_valid", longint'(dout_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cur_sel = clampsel(int'(dec_sel));
    idle(3);
  endtask

  task automatic start(input int s);
    dec_sel = 3'(s);
    do_reset();
    obs.delete();
  endtask

  // Output monitor: strobe timing, output value, and hold between strobes.
  always @(negedge clk) begin
    bit ev;
    if (expq.size() > 0 && expq[0].cyc < cyc) begin
      check("late_strobe", cyc, expq[0].cyc);
      void'(expq.pop_front());
    end
    ev = (expq.size() > 0 && expq[0].cyc == cyc);
    if (ev) begin
      exp_dout = expq[0].val;
      void'(expq.pop_front());
    end
    check("dout_valid", longint'(dout_valid), longint'(ev));
    check("dout", longint'(dout), longint'(exp_dout));
    if (dout_valid) obs.push_back(int'(dout));
  end

  initial begin
    int imp_exp[3];
    rst_n = 1'b0; din = '0; din_valid = 1'b0; dec_sel = 3'd0;
    repeat (2) @(posedge clk);
    #1;

    // DC gain at R=8.
    start(3);
    repeat (64) drive(1'b1, 1000);
    idle(3);
    check("dc_count", obs.size(), 8);
    for (int i = 3; i < 8 && i < obs.size(); i++) check("dc1000", obs[i], 1000);

    // Impulse response at R=2. The first strobe is the pipeline-fill output.
    start(1);
    drive(1'b1, 16384);
    repeat (11) drive(1'b1, 0);
    idle(3);
    check("imp_count", obs.size(), 6);
    if (obs.size() >= 5) begin
      check("imp_6144", obs[1], 6144);
      check("imp_2048", obs[2], 2048);
      check("imp_0a", obs[3], 0);
      check("imp_0b", obs[4], 0);
    end

    // Small impulse shows the truncation or rounding behaviour.
`ifdef CIC_ROUND_EN
    imp_exp = '{2, 1, 0};
`else
    imp_exp = '{1, 0, 0};
`endif
    start(1);
    drive(1'b1, 4);
    repeat (9) drive(1'b1, 0);
    idle(3);
    check("imp4_count", obs.size(), 5);
    for (int i = 0; i < 3 && i + 1 < obs.size(); i++) check("imp4", obs[i+1], imp_exp[i]);

    // Full-scale DC at the largest ratio.
    start(4);
    repeat (96) drive(1'b1, -32768);
    idle(3);
    check("dcneg_count", obs.size(), 6);
    if (obs.size() > 0) check("dcneg", obs[obs.size()-1], -32768);
    start(4);
    repeat (96) drive(1'b1, 32767);
    idle(3);
    check("dcpos_count", obs.size(), 6);
    if (obs.size() > 0) check("dcpos", obs[obs.size()-1], 32767);

    // Mid-frame ratio change 3->2 flushes state and drops coincident samples.
    start(3);
    repeat (5) drive(1'b1, rnd_sample());
    set_sel(2);
    repeat (14) drive(1'b1, rnd_sample());
    idle(3);
    check("flush_count", obs.size(), 3);

    // Reset pulsed mid-frame with gapped input.
    start(3);
    repeat (13) drive($urandom_range(0, 1) == 1, rnd_sample());
    do_reset();
    repeat (40) drive($urandom_range(0, 1) == 1, rnd_sample());
    idle(3);

    // Random ratio changes (including clamped values) and gapped input.
    start(0);
    for (int seg = 0; seg < 10; seg++) begin
      set_sel(int'($urandom_range(0, 7)));
      repeat ($urandom_range(10, 60)) drive($urandom_range(0, 3) != 0, rnd_sample());
    end
    idle(5);
    check("drain", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
